// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and the CRC tag function for pipelined_crc_alu.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;

  // Widest datapath the CRC function supports; callers zero-extend into this.
  localparam int unsigned CrcMaxW = 64;

  // (data * x^width) mod (x^width + poly), data shifted MSB-first, zero init.
  function automatic logic [CrcMaxW-1:0] crc_word(input logic [CrcMaxW-1:0] data,
                                                  input logic [CrcMaxW-1:0] poly,
                                                  input int unsigned        width);
    logic [CrcMaxW-1:0] crc;
    logic [CrcMaxW-1:0] mask;
    logic [CrcMaxW-1:0] dat;
    logic [CrcMaxW-1:0] top;
    logic               fb;
    crc  = '0;
    mask = (width >= CrcMaxW) ? '1 : ((CrcMaxW'(1) << width) - CrcMaxW'(1));
    dat  = data << (CrcMaxW - width);
    for (int unsigned i = 0; i < CrcMaxW; i++) begin
      if (i < width) begin
        top = crc << (CrcMaxW - width);
        fb  = dat[CrcMaxW-1] ^ top[CrcMaxW-1];
        crc = ((crc << 1) ^ (fb ? poly : '0)) & mask;
        dat = dat << 1;
      end
    end
    return crc;
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Bit-serial unsigned shift-add multiplier and restoring divider, one bit per cycle.
module iter_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             run_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  // x: multiplicand / dividend-then-quotient, y: multiplier / divisor,
  // acc: product accumulator / partial remainder.
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  always_comb begin
    rem_sh = {acc_q, x_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, y_q};
    if (is_div_i) begin
      y_d = y_q;
      if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], 1'b0};
      end
      result_o = x_d;
    end else begin
      acc_d    = y_q[0] ? acc_q + x_q : acc_q;
      x_d      = x_q << 1;
      y_d      = y_q >> 1;
      result_o = acc_d;
    end
  end

  assign done_o = run_i && (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      x_q   <= a_i;
      y_q   <= b_i;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (run_i) begin
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/pipelined_crc_alu.sv
// Handshaked ALU (ADD/SUB/MUL/DIV) with a registered CRC tag and error flag on the result.
module pipelined_crc_alu
  import alu_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] CRC_POLY = WIDTH'(32'h04C11DB7)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] crc_out,
  output logic             err
);

  state_e           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic             err_q, err_d;
  logic             fin;
  logic             accept;
  logic             div0;
  logic             iter_run;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;

  assign accept   = in_valid && (state_q == ST_IDLE);
  assign div0     = (op_q == OP_DIV) && (b_q == '0);
  assign iter_run = (state_q == ST_EXEC) && ((op_q == OP_MUL) || ((op_q == OP_DIV) && !div0));

  iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept),
    .run_i   (iter_run),
    .is_div_i(op_q == OP_DIV),
    .a_i     (a),
    .b_i     (b),
    .done_o  (iter_done),
    .result_o(iter_result)
  );

  always_comb begin
    result_d = '0;
    err_d    = 1'b0;
    fin      = 1'b1;
    case (op_q)
      OP_ADD: result_d = a_q + b_q;
      OP_SUB: result_d = a_q - b_q;
      OP_MUL: begin
        result_d = iter_result;
        fin      = iter_done;
      end
      OP_DIV: begin
        if (div0) begin
          result_d = '1;
          err_d    = 1'b1;
        end else begin
          result_d = iter_result;
          fin      = iter_done;
        end
      end
      default: err_d = 1'b1;
    endcase
    crc_d = WIDTH'(crc_word(CrcMaxW'(result_d), CrcMaxW'(CRC_POLY), WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      crc_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= opcode;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (fin) begin
            result_q <= result_d;
            crc_q    <= crc_d;
            err_q    <= err_d;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign crc_out   = crc_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pipelined_crc_alu.sv
// Scoreboard bench for pipelined_crc_alu: expected results queued at accept, checked at out_valid.
module tb_pipelined_crc_alu;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_r = '0;
  logic [31:0] b_r = '0;
  logic [3:0]  op_r = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [31:0] crc_out;
  logic        err;

  typedef struct {
    logic [31:0] res;
    logic [31:0] crc;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  pipelined_crc_alu #(
    .WIDTH   (32),
    .CRC_POLY(POLY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a_r),
    .b        (b_r),
    .opcode   (op_r),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .crc_out  (crc_out),
    .err      (err)
  );

  // Long division of d*x^32 by the full 33-bit generator.
  function automatic logic [31:0] ref_crc(input logic [31:0] d);
    logic [63:0] v;
    v = {d, 32'h0};
    for (int i = 63; i >= 32; i--) begin
      if (v[i]) v = v ^ (64'({1'b1, POLY}) << (i - 32));
    end
    return v[31:0];
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t        e;
    logic [63:0] p;
    e.err = 1'b0;
    e.lat = 1;
    case (op)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: begin
        p     = 64'(a) * 64'(b);
        e.res = p[31:0];
        e.lat = 32;
      end
      4'd3: begin
        if (b == 0) begin
          e.res = 32'hFFFF_FFFF;
          e.err = 1'b1;
        end else begin
          e.res = a / b;
          e.lat = 32;
        end
      end
      default: begin
        e.res = 32'h0;
        e.err = 1'b1;
      end
    endcase
    e.crc = ref_crc(e.res);
    sb.push_back(e);
  endtask

  // Present one operation while IDLE; returns just after its accept edge.
  task automatic accept_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    push_exp(a, b, op);
    a_r      = a;
    b_r      = b;
    op_r     = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_r      = $urandom;
    b_r      = $urandom;
    op_r     = 4'($urandom_range(0, 15));
    n_vec++;
    if (in_ready !== 1'b0) begin
      $display("FAIL accept: in_ready=%b after accept edge, required 0", in_ready);
      n_miss++;
    end
  endtask

  // Wait for out_valid (bounded) and check it against the oldest expectation.
  task automatic collect(input string name);
    exp_t e;
    int   lat;
    bit   ir_bad;
    lat    = 0;
    ir_bad = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid !== 1'b1 && in_ready !== 1'b0) ir_bad = 1;
    end
    e = sb.pop_front();
    n_vec++;
    if (out_valid !== 1'b1) begin
      $display("FAIL %s timeout: out_valid=%b after %0d edges, required 1", name, out_valid, lat);
      n_miss++;
      return;
    end
    n_vec++;
    if (lat != e.lat) begin
      $display("FAIL %s latency: got %0d edges, required %0d", name, lat, e.lat);
      n_miss++;
    end
    n_vec++;
    if (result !== e.res) begin
      $display("FAIL %s result: got %h, required %h", name, result, e.res);
      n_miss++;
    end
    n_vec++;
    if (crc_out !== e.crc) begin
      $display("FAIL %s crc_out: got %h, required %h", name, crc_out, e.crc);
      n_miss++;
    end
    n_vec++;
    if (err !== e.err) begin
      $display("FAIL %s err: got %b, required %b", name, err, e.err);
      n_miss++;
    end
    n_vec++;
    if (ir_bad) begin
      $display("FAIL %s in_ready: got 1 during EXEC, required 0", name);
      n_miss++;
    end
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL %s release: out_valid=%b in_ready=%b, required 0 1", name, out_valid,
               in_ready);
      n_miss++;
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || crc_out !== 32'h0 ||
        err !== 1'b0) begin
      $display("FAIL %s: in_ready=%b out_valid=%b result=%h crc=%h err=%b, required 1 0 0 0 0",
               name, in_ready, out_valid, result, crc_out, err);
      n_miss++;
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    a_r      = 32'd9;
    b_r      = 32'd9;
    op_r     = 4'd0;
    #3;
    check_reset_vals("reset_values");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset_held_with_in_valid");
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_vals("reset_released_no_accept");
  endtask

  task automatic test_addsub();
    accept_op(32'h0, 32'h1, 4'd0);
    collect("add_0_1");
    n_vec++;
    if (crc_out !== 32'h04C11DB7) begin
      $display("FAIL add_0_1 crc_const: got %h, required 04c11db7", crc_out);
      n_miss++;
    end
    release_out("add_0_1");
    accept_op(32'h0, 32'h1, 4'd1);
    collect("sub_0_1");
    release_out("sub_0_1");
    accept_op(32'h0, 32'h2, 4'd0);
    collect("add_0_2");
    n_vec++;
    if (crc_out !== 32'h09823B6E) begin
      $display("FAIL add_0_2 crc_const: got %h, required 09823b6e", crc_out);
      n_miss++;
    end
    release_out("add_0_2");
    accept_op(32'hFFFF_FFFF, 32'h1, 4'd0);
    collect("add_wrap");
    release_out("add_wrap");
  endtask

  task automatic test_mul();
    accept_op(32'h0001_0000, 32'h0001_0003, 4'd2);
    collect("mul_wrap");
    n_vec++;
    if (result !== 32'h0003_0000) begin
      $display("FAIL mul_wrap const: got %h, required 00030000", result);
      n_miss++;
    end
    release_out("mul_wrap");
    accept_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
    collect("mul_max");
    release_out("mul_max");
  endtask

  task automatic test_div();
    accept_op(32'd100, 32'd7, 4'd3);
    collect("div_100_7");
    n_vec++;
    if (result !== 32'd14) begin
      $display("FAIL div_100_7 const: got %0d, required 14", result);
      n_miss++;
    end
    release_out("div_100_7");
    accept_op(32'd5, 32'd0, 4'd3);
    collect("div_by_zero");
    release_out("div_by_zero");
    accept_op(32'd3, 32'hFFFF_FFFF, 4'd3);
    collect("div_small");
    release_out("div_small");
    accept_op(32'hFFFF_FFFF, 32'd1, 4'd3);
    collect("div_by_one");
    release_out("div_by_one");
    accept_op(32'h1234, 32'h5678, 4'hF);
    collect("illegal_op");
    release_out("illegal_op");
  endtask

  task automatic test_backpressure();
    logic [31:0] hr, hc;
    logic        he;
    accept_op(32'h1234_5678, 32'h9ABC_DEF1, 4'd2);
    collect("bp_mul");
    hr       = result;
    hc       = crc_out;
    he       = err;
    a_r      = 32'd10;
    b_r      = 32'd20;
    op_r     = 4'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== hr || crc_out !== hc ||
          err !== he) begin
        $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b result=%h crc=%h err=%b", i,
                 out_valid, in_ready, result, crc_out, err);
        n_miss++;
      end
    end
    push_exp(32'd10, 32'd20, 4'd0);
    release_out("bp_handshake_no_accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      $display("FAIL bp_accept_next: in_ready=%b, required 0", in_ready);
      n_miss++;
    end
    collect("bp_add");
    release_out("bp_add");
  endtask

  task automatic test_reset_mid();
    exp_t dropped;
    accept_op(32'd100, 32'd7, 4'd3);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("reset_mid_exec");
    dropped = sb.pop_back();
    @(posedge clk);
    #1;
    rst = 1'b0;
    accept_op(32'd3, 32'd4, 4'd0);
    collect("add_after_reset");
    n_vec++;
    if (result !== 32'd7) begin
      $display("FAIL add_after_reset const: got %0d, required 7", result);
      n_miss++;
    end
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("reset_mid_done");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [3:0]  op;
    for (int i = 0; i < 10; i++) begin
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      op = (i == 9) ? 4'd7 : 4'($urandom_range(0, 3));
      accept_op(a, b, op);
      collect("b2b");
      release_out("b2b");
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
